// File: rtl/serial_add_sched.sv
// ============================================================================
// Module   : serial_add_sched
// Brief    : Two-requester scheduler that computes A+B+cin two bits per cycle
//            on one shared 2-bit ripple slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_sum,
    output logic               resp_cout,
    output logic               resp_id
);

    localparam int c_NUM_DIGITS = WIDTH / 2;
    localparam int c_CNT_W      = $clog2(c_NUM_DIGITS);
    localparam logic [c_CNT_W-1:0] c_LAST_DIGIT = c_CNT_W'(c_NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_id;
    logic               r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [1:0] w_grant;
    logic [1:0] w_ready;
    logic       w_accept;
    logic       w_acc_id;
    logic       w_s0;
    logic       w_s1;
    logic       w_c1;
    logic       w_co;

    // Operands shift right each ADD cycle, so digit k always sits in bits 1:0.
    always_comb begin
        w_s0 = r_a[0] ^ r_b[0] ^ r_carry;
        w_c1 = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
        w_s1 = r_a[1] ^ r_b[1] ^ w_c1;
        w_co = (r_a[1] & r_b[1]) | (r_a[1] & w_c1) | (r_b[1] & w_c1);
    end

    always_comb begin
        w_grant = req_valid;
        if (req_valid == 2'b11) begin
            w_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 2'b00;
        case (r_state)
            S_IDLE: begin
                // Gated by rst so no grant is visible while reset is held.
                w_ready = rst ? 2'b00 : w_grant;
                if (|w_grant) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                if (r_cnt == c_LAST_DIGIT) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = |(req_valid & w_ready);
    assign w_acc_id = w_ready[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_id    <= 1'b0;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_acc_id ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
                        r_b     <= w_acc_id ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
                        r_carry <= req_cin[w_acc_id];
                        r_id    <= w_acc_id;
                        r_ptr   <= ~w_acc_id;
                        r_cnt   <= '0;
                    end
                end
                S_ADD: begin
                    r_a                       <= r_a >> 2;
                    r_b                       <= r_b >> 2;
                    r_sum[{r_cnt, 1'b0} +: 2] <= {w_s1, w_s0};
                    r_carry                   <= w_co;
                    r_cnt                     <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_DIGIT) begin
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = w_ready;
    assign resp_valid = (r_state == S_DONE);
    assign resp_sum   = r_sum;
    assign resp_cout  = r_cout;
    assign resp_id    = r_id;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sched.sv
// ============================================================================
// Module   : tb_serial_add_sched
// Brief    : Scoreboard bench for serial_add_sched (directed + random vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sched;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [W-1:0]  resp_sum;
    logic          resp_cout;
    logic          resp_id;

    logic          tb_v   [2];
    logic [W-1:0]  tb_a   [2];
    logic [W-1:0]  tb_b   [2];
    logic          tb_cin [2];

    logic [1:0]    req_valid;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]    req_cin;

    assign req_valid = {tb_v[1], tb_v[0]};
    assign req_a     = {tb_a[1], tb_a[0]};
    assign req_b     = {tb_b[1], tb_b[0]};
    assign req_cin   = {tb_cin[1], tb_cin[0]};

    int            total = 0;
    int            bad   = 0;
    logic [17:0]   sb[$];
    int            glog[$];
    logic          rr_rand = 1'b0;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] es, input logic ec);
        int n = 0;
        tb_a[i] = a; tb_b[i] = b; tb_cin[i] = cin; tb_v[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 2000);
        if (!req_ready[i]) begin
            total++; bad++;
            $display("FAIL grant_timeout: requester %0d never granted", i);
        end else begin
            sb.push_back({i[0], ec, es});
            glog.push_back(i);
        end
        @(posedge clk); #1;
        tb_v[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || resp_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic rand_stream(input int i, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         c;
            logic [W:0]   r;
            int           gap;
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom_range(0, 1));
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            send(i, a, b, c, r[W-1:0], r[W]);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: got id=%0d sum=0x%0h with none required", resp_id, resp_sum);
            end else begin
                check("resp", {14'd0, resp_id, resp_cout, resp_sum}, {14'd0, sb.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(req_ready) > 1) begin
                total++; bad++;
                $display("FAIL ready_onehot: got 0x%0h required at most one bit", req_ready);
            end
            if (resp_valid && req_ready != 2'b00) begin
                total++; bad++;
                $display("FAIL ready_in_done: got 0x%0h required 0x0", req_ready);
            end
        end
    end

    always @(posedge clk) begin
        if (rr_rand) begin
            #1 resp_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic stuck;
        for (int i = 0; i < 2; i++) begin
            tb_v[i] = 1'b1; tb_a[i] = 16'h1111; tb_b[i] = 16'h2222; tb_cin[i] = 1'b1;
        end

        // Reset state, with both requesters valid to prove grants are gated.
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", resp_valid, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_cout", resp_cout, 0);
        check("rst_id", resp_id, 0);
        check("rst_ready", req_ready, 0);
        tb_v[0] = 1'b0; tb_v[1] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Carry through every digit; latency and DONE hold behaviour.
        resp_ready = 1'b0;
        send(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        repeat (7) @(posedge clk);
        #1 check("lat_before", resp_valid, 0);
        @(posedge clk);
        #1 check("lat_at", resp_valid, 1);
        tb_a[1] = 16'h1234; tb_b[1] = 16'h4321; tb_cin[1] = 1'b1; tb_v[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_sum", resp_sum, 16'h0000);
            check("hold_cout", resp_cout, 1);
            check("hold_id", resp_id, 0);
            check("hold_ready", req_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk); #1 check("consumed", resp_valid, 0);

        send(1, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);
        drain();

        // Both requesters valid continuously after reset: alternating grants.
        rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;
        glog.delete();
        fork
            begin
                send(0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
                send(0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
            end
            begin
                send(1, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);
                send(1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
            end
        join
        drain();
        check("grant_count", glog.size(), 4);
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            check("grant_order", glog[k], k % 2);
        end

        // Reset after the 4th ADD edge abandons the operation.
        send(0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_valid", resp_valid, 0);
        check("midrst_sum", resp_sum, 0);
        #1 rst = 1'b0;
        stuck = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) stuck = 1'b1;
        end
        check("no_resp_after_rst", stuck, 0);
        @(posedge clk); #1;
        send(1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
        drain();

        // Random operands from both requesters under random back-pressure.
        rr_rand = 1'b1;
        fork
            rand_stream(0, 12);
            rand_stream(1, 12);
        join
        rr_rand = 1'b0;
        #2 resp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
